// File: rtl/mult_pkg.sv
// Shared constants for the fixed-point multiplier pipeline (MULT_SAT_EN consumers use the limits).
// Latency: n/a, no logic.
// Backpressure: n/a.
package mult_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // Representable range of a WIDTH-bit two's-complement lane, evaluated in 64 bits.
  function automatic longint sat_hi(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/mult_lane.sv
// One lane: signed fixed-point multiply, optional round, shift, overflow detect, wrap or clamp (MULT_SAT_EN).
// Latency: STAGES cycles; product registered in stage 1, plain delay registers after, scaling in the final stage.
// Backpressure: every register holds while en is low.
module mult_lane
  import mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int STAGES     = 2,
  parameter int ROUND      = ROUND_TRUNC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic        [WIDTH-1:0] result,
  output logic                    ovf
);

  localparam int PW      = 2 * WIDTH;
  localparam int SW      = PW + 1;  // one bit of headroom for the rounding addend
  localparam int RND_POS = (FRAC_WIDTH > 0) ? FRAC_WIDTH - 1 : 0;

  localparam logic signed [SW-1:0] LIM_HI  = SW'(sat_hi(WIDTH));
  localparam logic signed [SW-1:0] LIM_LO  = SW'(sat_lo(WIDTH));
  localparam logic signed [SW-1:0] RND_ADD =
      (ROUND == ROUND_HALF_UP && FRAC_WIDTH > 0) ? (SW'(1) <<< RND_POS) : '0;

  logic signed [PW-1:0]    prod_c;
  logic signed [PW-1:0]    prod_fin;
  logic signed [SW-1:0]    rounded;
  logic signed [SW-1:0]    scaled;
  logic                    ovf_c;
  logic        [WIDTH-1:0] res_c;

  assign prod_c = PW'(a) * PW'(b);

  if (STAGES == 1) begin : g_single
    assign prod_fin = prod_c;
  end else begin : g_multi
    logic signed [PW-1:0] prod_q [STAGES-1];

    always_ff @(posedge clk) begin
      if (en) begin
        prod_q[0] <= prod_c;
        for (int s = 1; s < STAGES - 1; s++) begin
          prod_q[s] <= prod_q[s-1];
        end
      end
    end

    assign prod_fin = prod_q[STAGES-2];
  end

  always_comb begin
    rounded = SW'(prod_fin) + RND_ADD;
    scaled  = rounded >>> FRAC_WIDTH;
    ovf_c   = (scaled > LIM_HI) || (scaled < LIM_LO);
    res_c   = scaled[WIDTH-1:0];
`ifdef MULT_SAT_EN
    if (ovf_c) begin
      res_c = scaled[SW-1] ? LIM_LO[WIDTH-1:0] : LIM_HI[WIDTH-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      ovf    <= 1'b0;
    end else if (en) begin
      result <= res_c;
      ovf    <= ovf_c;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// LANES-wide signed fixed-point multiplier with a shared valid/ready handshake (MULT_SAT_EN: clamp on overflow).
// Latency: STAGES cycles per beat plus one per stall cycle; one beat per cycle when out_ready stays high.
// Backpressure: stall-all; in_ready = out_ready || !out_valid, combinational, independent of in_valid.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int STAGES     = 2,
  parameter int ROUND      = ROUND_TRUNC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] op_a,
  input  logic [LANES*WIDTH-1:0] op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       ovf
);

  logic              adv;
  logic [STAGES-1:0] vld_q;

  // A bubble may be overwritten even when downstream is not ready.
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mult_lane #(
      .WIDTH      (WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .STAGES     (STAGES),
      .ROUND      (ROUND)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (adv),
      .a      (op_a[i*WIDTH +: WIDTH]),
      .b      (op_b[i*WIDTH +: WIDTH]),
      .result (result[i*WIDTH +: WIDTH]),
      .ovf    (ovf[i])
    );
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: 1-lane/2-stage truncating instance and 4-lane/4-stage rounding instance.
// Expected beats are queued on acceptance and compared on each output transfer.
module tb_mult_pipe;
  import mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_op_a, a_op_b, a_result;
  logic [0:0]  a_ovf;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_op_a, b_op_b, b_result;
  logic [3:0]  b_ovf;

  mult_pipe #(.WIDTH(16), .FRAC_WIDTH(8), .LANES(1), .STAGES(2), .ROUND(ROUND_TRUNC)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op_a(a_op_a), .op_b(a_op_b), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result(a_result), .ovf(a_ovf));

  mult_pipe #(.WIDTH(16), .FRAC_WIDTH(8), .LANES(4), .STAGES(4), .ROUND(ROUND_HALF_UP)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op_a(b_op_a), .op_b(b_op_b), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .result(b_result), .ovf(b_ovf));

`ifdef MULT_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;  // 0x7F00*0x0200
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;  // 0x8000*0x0200
  localparam logic [15:0] EXP_SQ_OVF  = 16'h7FFF;  // 0x8000*0x8000
`else
  localparam logic [15:0] EXP_POS_OVF = 16'hFE00;
  localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
  localparam logic [15:0] EXP_SQ_OVF  = 16'h0000;
`endif

  typedef struct {
    logic [63:0] res;
    logic [3:0]  ovf;
    int          cyc;
    int          stl;
  } exp_t;

  exp_t        qa[$], qb[$];
  exp_t        ea, eb;
  logic [63:0] a_cur_res, b_cur_res;
  logic [3:0]  a_cur_ovf, b_cur_ovf;
  int          tests = 0, fails = 0;
  int          cyc = 0, a_stl = 0, b_stl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact product, optional half-up addend, floor division by 2^8, range test.
  function automatic logic [16:0] ref_lane(input logic [15:0] x, input logic [15:0] y, input bit rnd);
    longint p, s;
    logic   ov;
    p = longint'($signed(x)) * longint'($signed(y));
    if (rnd) p = p + 128;
    s = p >>> 8;
    ov = (s > 32767) || (s < -32768);
`ifdef MULT_SAT_EN
    if (ov) s = (s > 0) ? 32767 : -32768;
`endif
    return {ov, s[15:0]};
  endfunction

  function automatic logic [15:0] rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 1) == 1) v = {{7{v[8]}}, v[8:0]};
    return v;
  endfunction

  // ---------------- monitors ----------------
  logic        a_prev_stall = 1'b0, b_prev_stall = 1'b0;
  logic [15:0] a_prev_res;
  logic [63:0] b_prev_res;
  logic [0:0]  a_prev_ovf;
  logic [3:0]  b_prev_ovf;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_prev_stall = 1'b0;
    end else begin
      if (a_in_valid && a_in_ready) qa.push_back('{a_cur_res, a_cur_ovf, cyc, a_stl});
      check("a_in_ready", 64'(a_in_ready), 64'(a_out_ready || !a_out_valid));
      if (a_prev_stall) begin
        check("a_hold_result", 64'(a_result), 64'(a_prev_res));
        check("a_hold_ovf", 64'(a_ovf), 64'(a_prev_ovf));
        check("a_hold_valid", 64'(a_out_valid), 64'd1);
      end
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          tests++; fails++;
          $display("FAIL a_spurious: result %0h emitted, no beat outstanding", a_result);
        end else begin
          ea = qa.pop_front();
          check("a_result", 64'(a_result), 64'(ea.res[15:0]));
          check("a_ovf", 64'(a_ovf), 64'(ea.ovf[0]));
          check("a_latency", 64'(cyc - ea.cyc), 64'(2 + a_stl - ea.stl));
        end
      end
      a_prev_stall = a_out_valid && !a_out_ready;
      if (a_prev_stall) a_stl++;
      a_prev_res = a_result;
      a_prev_ovf = a_ovf;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_prev_stall = 1'b0;
    end else begin
      if (b_in_valid && b_in_ready) qb.push_back('{b_cur_res, b_cur_ovf, cyc, b_stl});
      check("b_in_ready", 64'(b_in_ready), 64'(b_out_ready || !b_out_valid));
      if (b_prev_stall) begin
        check("b_hold_result", b_result, b_prev_res);
        check("b_hold_ovf", 64'(b_ovf), 64'(b_prev_ovf));
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_spurious: result %0h emitted, no beat outstanding", b_result);
        end else begin
          eb = qb.pop_front();
          check("b_result", b_result, eb.res);
          check("b_ovf", 64'(b_ovf), 64'(eb.ovf));
          check("b_latency", 64'(cyc - eb.cyc), 64'(4 + b_stl - eb.stl));
        end
      end
      b_prev_stall = b_out_valid && !b_out_ready;
      if (b_prev_stall) b_stl++;
      b_prev_res = b_result;
      b_prev_ovf = b_ovf;
    end
  end

  // ---------------- drivers (called at posedge + #1) ----------------
  task automatic send_a(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic eo);
    int n = 0;
    a_op_a = x; a_op_b = y; a_cur_res = 64'(er); a_cur_ovf = 4'(eo); a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin n++; @(negedge clk); end
    if (!a_in_ready) begin
      tests++; fails++;
      $display("FAIL a_accept_timeout: in_ready %0b after %0d cycles, required 1", a_in_ready, n);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] er, input logic [3:0] eo);
    int n = 0;
    b_op_a = x; b_op_b = y; b_cur_res = er; b_cur_ovf = eo; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && n < 200) begin n++; @(negedge clk); end
    if (!b_in_ready) begin
      tests++; fails++;
      $display("FAIL b_accept_timeout: in_ready %0b after %0d cycles, required 1", b_in_ready, n);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic send_a_rand();
    logic [15:0] x, y;
    logic [16:0] r;
    x = rnd16(); y = rnd16();
    r = ref_lane(x, y, 1'b0);
    send_a(x, y, r[15:0], r[16]);
  endtask

  task automatic send_b_rand();
    logic [63:0] x, y, er;
    logic [3:0]  eo;
    logic [16:0] r;
    for (int l = 0; l < 4; l++) begin
      x[l*16 +: 16] = rnd16();
      y[l*16 +: 16] = rnd16();
      r = ref_lane(x[l*16 +: 16], y[l*16 +: 16], 1'b1);
      er[l*16 +: 16] = r[15:0];
      eo[l] = r[16];
    end
    send_b(x, y, er, eo);
  endtask

  // ---------------- directed vectors, instance A (truncating) ----------------
  logic [15:0] da [6] = '{16'h0180, 16'hFF00, 16'h0001, 16'hFFFF, 16'h7F00, 16'h8000};
  logic [15:0] db [6] = '{16'h0200, 16'h0100, 16'h0080, 16'h0080, 16'h0200, 16'h0200};
  logic [15:0] dr [6] = '{16'h0300, 16'hFF00, 16'h0000, 16'hFFFF, EXP_POS_OVF, EXP_NEG_OVF};
  logic        dv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_op_a = '0; a_op_b = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_op_a = '0; b_op_b = '0;
    a_cur_res = '0; a_cur_ovf = '0; b_cur_res = '0; b_cur_ovf = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_result", 64'(a_result), 64'd0);
    check("rst_a_ovf", 64'(a_ovf), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_result", b_result, 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    rst_n = 1'b1;

    // Directed corner values, streamed back to back from the first cycle after release.
    for (int i = 0; i < 6; i++) send_a(da[i], db[i], dr[i], dv[i]);

    // Five-beat stream with a three-cycle downstream stall in the middle.
    fork
      for (int i = 0; i < 5; i++) send_a_rand();
      begin
        repeat (3) @(posedge clk);
        #1 a_out_ready = 1'b0;
        #1 check("a_full_in_ready", 64'(a_in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join

    // Random operands, random gaps, random backpressure.
    fork
      for (int i = 0; i < 150; i++) begin
        send_a_rand();
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      begin
        repeat (300) begin @(posedge clk); #1 a_out_ready = ($urandom_range(0, 2) != 0); end
        a_out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset with two beats in flight.
    send_a(16'h0180, 16'h0200, 16'h0300, 1'b0);
    send_a(16'h0200, 16'h0200, 16'h0400, 1'b0);
    check("a_inflight_valid", 64'(a_out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("arst_a_result", 64'(a_result), 64'd0);
    check("arst_a_ovf", 64'(a_ovf), 64'd0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("a_no_stale", 64'(a_out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Instance B: four lanes, four stages, round half up.
    send_b({16'h0180, 16'h7F00, 16'hFFFF, 16'h0001},
           {16'h0200, 16'h0200, 16'h0080, 16'h0080},
           {16'h0300, EXP_POS_OVF, 16'h0000, 16'h0001}, 4'b0100);
    send_b({16'h8000, 16'h0100, 16'hFF00, 16'h8000},
           {16'h8000, 16'h0100, 16'h0100, 16'h0200},
           {EXP_SQ_OVF, 16'h0100, 16'hFF00, EXP_NEG_OVF}, 4'b1001);
    fork
      for (int i = 0; i < 120; i++) begin
        send_b_rand();
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      begin
        repeat (250) begin @(posedge clk); #1 b_out_ready = ($urandom_range(0, 2) != 0); end
        b_out_ready = 1'b1;
      end
    join

    for (int k = 0; k < 100 && (qa.size() != 0 || qb.size() != 0); k++) @(posedge clk);
    #1;
    check("a_drain", 64'(qa.size()), 64'd0);
    check("b_drain", 64'(qb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
